st_rs_queue: RTL

ST_RS_QUEUE -- requirements
Module: st_rs_queue

---
 rtl/st_rs_queue_pkg.sv | 26 ++
 rtl/st_rs_queue_if.sv | 36 +++
 rtl/st_rs_entry.sv | 82 ++++++++
 rtl/st_rs_queue.sv | 97 +++++++++
 4 files changed

// File: rtl/st_rs_queue_pkg.sv
// Shared constants for the reservation-station family: tag numbering,
// the reserved "operand valid" tag and default datapath widths.
package st_rs_queue_pkg;

  // Datapath defaults shared by every reservation station
  localparam int DW_DEF = 64;
  localparam int TW_DEF = 4;

  // Tag 0 means the operand value is already present
  localparam int NOTAG = 0;

  // First tag owned by each station group; a group owns consecutive tags
  localparam int ADD_TAG_BASE  = 1;
  localparam int MULT_TAG_BASE = 4;
  localparam int LD_TAG_BASE   = 6;
  localparam int ST_TAG_BASE   = 9;

  // Station group identifiers
  typedef enum logic [1:0] {
    RS_ADD,
    RS_MULT,
    RS_LD,
    RS_ST
  } rs_kind_e;

endpackage

// File: rtl/st_rs_queue_if.sv
// Bundle of issue, CDB and memory-side signals of the store queue.
// The slave side is the queue itself; the master side is its environment.
interface st_rs_queue_if import st_rs_queue_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int TW = TW_DEF
);
  logic          iss_valid;
  logic          iss_ready;
  logic [DW-1:0] iss_vj;
  logic [TW-1:0] iss_qj;
  logic [DW-1:0] iss_vk;
  logic [TW-1:0] iss_qk;
  logic [DW-1:0] iss_offset;
  logic [TW-1:0] iss_tag;
  logic          flush;
  logic          cdb_valid;
  logic [TW-1:0] cdb_id;
  logic [DW-1:0] cdb_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [TW-1:0] mem_tag;

  modport master (
    output iss_valid, iss_vj, iss_qj, iss_vk, iss_qk, iss_offset,
    output flush, cdb_valid, cdb_id, cdb_data, mem_ready,
    input  iss_ready, iss_tag, mem_valid, mem_addr, mem_data, mem_tag
  );

  modport slave (
    input  iss_valid, iss_vj, iss_qj, iss_vk, iss_qk, iss_offset,
    input  flush, cdb_valid, cdb_id, cdb_data, mem_ready,
    output iss_ready, iss_tag, mem_valid, mem_addr, mem_data, mem_tag
  );
endinterface

// File: rtl/st_rs_entry.sv
// One store-queue slot: holds store data, base, offset and the two
// producer tags, and snoops the CDB to resolve outstanding operands.
module st_rs_entry import st_rs_queue_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int TW = TW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_en,
  input  logic          free,
  input  logic [DW-1:0] wr_vj,
  input  logic [TW-1:0] wr_qj,
  input  logic [DW-1:0] wr_vk,
  input  logic [TW-1:0] wr_qk,
  input  logic [DW-1:0] wr_offset,
  input  logic          cdb_valid,
  input  logic [TW-1:0] cdb_id,
  input  logic [DW-1:0] cdb_data,
  output logic          busy,
  output logic          ready,
  output logic [DW-1:0] vj,
  output logic [DW-1:0] vk,
  output logic [DW-1:0] offset
);
  localparam logic [TW-1:0] NO_TAG = TW'(NOTAG);

  logic [TW-1:0] qj;
  logic [TW-1:0] qk;
  logic          hit_j;
  logic          hit_k;
  logic          byp_j;
  logic          byp_k;

  // Tag matches against the broadcast, for stored tags and for issuing tags
  always_comb begin
    hit_j = cdb_valid && (qj != NO_TAG) && (qj == cdb_id);
    hit_k = cdb_valid && (qk != NO_TAG) && (qk == cdb_id);
    byp_j = cdb_valid && (wr_qj != NO_TAG) && (wr_qj == cdb_id);
    byp_k = cdb_valid && (wr_qk != NO_TAG) && (wr_qk == cdb_id);
  end

  assign ready = busy && (qj == NO_TAG) && (qk == NO_TAG);

  // Slot storage: flush beats issue, issue beats release/snoop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      qj     <= NO_TAG;
      qk     <= NO_TAG;
      vj     <= '0;
      vk     <= '0;
      offset <= '0;
    end else if (flush) begin
      busy   <= 1'b0;
      qj     <= NO_TAG;
      qk     <= NO_TAG;
      vj     <= '0;
      vk     <= '0;
      offset <= '0;
    end else if (wr_en) begin
      busy   <= 1'b1;
      vj     <= byp_j ? cdb_data : wr_vj;
      qj     <= byp_j ? NO_TAG : wr_qj;
      vk     <= byp_k ? cdb_data : wr_vk;
      qk     <= byp_k ? NO_TAG : wr_qk;
      offset <= wr_offset;
    end else begin
      if (free) begin
        busy <= 1'b0;
      end
      if (busy && hit_j) begin
        vj <= cdb_data;
        qj <= NO_TAG;
      end
      if (busy && hit_k) begin
        vk <= cdb_data;
        qk <= NO_TAG;
      end
    end
  end
endmodule

// File: rtl/st_rs_queue.sv
// In-order store reservation queue: circular buffer of st_rs_entry slots,
// issuing at the tail and releasing only the head to memory.
module st_rs_queue import st_rs_queue_pkg::*; #(
  parameter int DW       = DW_DEF,
  parameter int TW       = TW_DEF,
  parameter int N_ENT    = 4,
  parameter int TAG_BASE = ST_TAG_BASE
) (
  input  logic                         clk,
  input  logic                         rst,
  st_rs_queue_if.slave                 bus,
  output logic [$clog2(N_ENT+1)-1:0]   count
);
  localparam int PW = (N_ENT > 1) ? $clog2(N_ENT) : 1;
  localparam int CW = $clog2(N_ENT+1);

  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW-1:0]    head_inc;
  logic [PW-1:0]    tail_inc;
  logic             iss_ready_int;
  logic             mem_valid_int;
  logic             head_busy;
  logic             accept;
  logic             dispatch;
  logic [N_ENT-1:0] ent_busy;
  logic [N_ENT-1:0] ent_ready;
  logic [DW-1:0]    ent_vj  [N_ENT];
  logic [DW-1:0]    ent_vk  [N_ENT];
  logic [DW-1:0]    ent_off [N_ENT];

  // Handshake decode and wrapping pointer increments
  always_comb begin
    iss_ready_int = (count < CW'(N_ENT));
    head_busy     = ent_busy[head];
    mem_valid_int = ent_ready[head];
    accept        = bus.iss_valid && iss_ready_int && !bus.flush;
    dispatch      = mem_valid_int && bus.mem_ready && !bus.flush;
    head_inc      = (head == PW'(N_ENT-1)) ? '0 : head + PW'(1);
    tail_inc      = (tail == PW'(N_ENT-1)) ? '0 : tail + PW'(1);
  end

  for (genvar i = 0; i < N_ENT; i++) begin : g_ent
    st_rs_entry #(.DW(DW), .TW(TW)) u_ent (
      .clk       (clk),
      .rst       (rst),
      .flush     (bus.flush),
      .wr_en     (accept && (tail == PW'(i))),
      .free      (dispatch && (head == PW'(i))),
      .wr_vj     (bus.iss_vj),
      .wr_qj     (bus.iss_qj),
      .wr_vk     (bus.iss_vk),
      .wr_qk     (bus.iss_qk),
      .wr_offset (bus.iss_offset),
      .cdb_valid (bus.cdb_valid),
      .cdb_id    (bus.cdb_id),
      .cdb_data  (bus.cdb_data),
      .busy      (ent_busy[i]),
      .ready     (ent_ready[i]),
      .vj        (ent_vj[i]),
      .vk        (ent_vk[i]),
      .offset    (ent_off[i])
    );
  end

  assign bus.iss_ready = iss_ready_int;
  assign bus.iss_tag   = TW'(TAG_BASE) + TW'(tail);
  assign bus.mem_valid = mem_valid_int;
  assign bus.mem_addr  = head_busy ? (ent_vk[head] + ent_off[head]) : '0;
  assign bus.mem_data  = head_busy ? ent_vj[head] : '0;
  assign bus.mem_tag   = head_busy ? (TW'(TAG_BASE) + TW'(head)) : '0;

  // Pointer and occupancy tracking; flush empties the queue outright
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (bus.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (accept) begin
        tail <= tail_inc;
      end
      if (dispatch) begin
        head <= head_inc;
      end
      case ({accept, dispatch})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule
